// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Groups are 4 bits wide; a second lookahead level spans blocks of 4 groups.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  function automatic int cla_groups(input int width);
    return width / CLA_GROUP;
  endfunction

  function automatic int cla_blocks(input int width);
    return (cla_groups(width) + CLA_GROUP - 1) / CLA_GROUP;
  endfunction

  // {group generate, group propagate} of one 4-bit group
  function automatic logic [1:0] cla_gp4(input logic [3:0] p, input logic [3:0] g);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// 4-wide lookahead unit: used for in-group bit carries and for group carries
// across a block of 4 groups.
module cla_lookahead4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [3:0] c,
  output logic       gg,
  output logic       gp,
  output logic       co
);
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp   = &p;
  assign co   = gg | (gp & ci);
endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on
// both sides; stage 1 holds p/g and group G/P, stage 2 resolves carries.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG     = cla_groups(WIDTH);
  localparam int NB     = cla_blocks(WIDTH);
  localparam int STAGES = 2;

  if (WIDTH % CLA_GROUP != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic             c0;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic [STAGES:1]  vld_pipe;
  logic             accept, s2_load;
  logic [WIDTH-1:0] b_eff, p_d, g_d;
  logic [NG-1:0]    gg_d, gp_d;
  s1_t              s1_d, s1_q;
  res_t             res_d, res_q;

  // ---------------- stage 1: conditioning, p/g, group G/P
  assign b_eff = sub ? ~b : b;
  assign p_d   = a ^ b_eff;
  assign g_d   = a & b_eff;

  for (genvar j = 0; j < NG; j++) begin : g_grp_gp
    assign {gg_d[j], gp_d[j]} = cla_gp4(p_d[4*j +: 4], g_d[4*j +: 4]);
  end

  assign s1_d = {p_d, g_d, gg_d, gp_d, sub ? ~cin : cin};

  // ---------------- stage 2: block-level then in-group carries
  logic [NB*4-1:0]  gg_pad, gp_pad, gc_pad;
  logic [NB:0]      bc;
  logic [NB-1:0]    blk_gg, blk_gp;
  logic [WIDTH-1:0] c_bit;
  logic [NG-1:0]    grp_gg, grp_gp, grp_co;

  // unused trailing groups of the last block have P=G=0
  always_comb begin
    gg_pad         = '0;
    gp_pad         = '0;
    gg_pad[NG-1:0] = s1_q.gg;
    gp_pad[NG-1:0] = s1_q.gp;
  end

  assign bc[0] = s1_q.c0;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla_lookahead4 u_blk (
      .p  (gp_pad[4*k +: 4]),
      .g  (gg_pad[4*k +: 4]),
      .ci (bc[k]),
      .c  (gc_pad[4*k +: 4]),
      .gg (blk_gg[k]),
      .gp (blk_gp[k]),
      .co (bc[k+1])
    );
  end

  for (genvar j = 0; j < NG; j++) begin : g_grp
    cla_lookahead4 u_grp (
      .p  (s1_q.p[4*j +: 4]),
      .g  (s1_q.g[4*j +: 4]),
      .ci (gc_pad[j]),
      .c  (c_bit[4*j +: 4]),
      .gg (grp_gg[j]),
      .gp (grp_gp[j]),
      .co (grp_co[j])
    );
  end

  logic unused_ok;
  assign unused_ok = ^{blk_gg, blk_gp, bc[NB], grp_gg, grp_gp, grp_co, gc_pad};

  assign res_d.s    = s1_q.p ^ c_bit;
  assign res_d.cout = grp_co[NG-1];
  assign res_d.ovf  = c_bit[WIDTH-1] ^ grp_co[NG-1];
  assign res_d.zero = ~|res_d.s;

  // ---------------- handshake: whole pipe stalls together
  assign in_ready = ~vld_pipe[1] | ~vld_pipe[2] | out_ready;
  assign accept   = in_valid & in_ready;
  assign s2_load  = vld_pipe[1] & (~vld_pipe[2] | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      res_q    <= '0;
    end else begin
      if (accept)  s1_q  <= s1_d;
      if (s2_load) res_q <= res_d;
      vld_pipe[1] <= accept  | (vld_pipe[1] & ~s2_load);
      vld_pipe[2] <= s2_load | (vld_pipe[2] & ~out_ready);
    end
  end

  assign out_valid = vld_pipe[2];
  assign s         = res_q.s;
  assign cout      = res_q.cout;
  assign ovf       = res_q.ovf;
  assign zero      = res_q.zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed/table bench for cla_pipe_adder at WIDTH 32, 4 and 64 sharing one
// set of control signals; 32-bit table results are hand-computed.
module tb_cla_pipe_adder;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic [3:0]  a4 = '0, b4 = '0, s4;
  logic [63:0] a64 = '0, b64 = '0, s64;
  logic        ir32, ov32, co32, of32, z32;
  logic        ir4, ov4, co4, of4, z4;
  logic        ir64, ov64, co64, of64, z64;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .a(a32), .b(b32),
    .sub(sub), .cin(cin), .out_valid(ov32), .out_ready(out_ready), .s(s32), .cout(co32),
    .ovf(of32), .zero(z32));
  cla_pipe_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .a(a4), .b(b4),
    .sub(sub), .cin(cin), .out_valid(ov4), .out_ready(out_ready), .s(s4), .cout(co4),
    .ovf(of4), .zero(z4));
  cla_pipe_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .a(a64), .b(b64),
    .sub(sub), .cin(cin), .out_valid(ov64), .out_ready(out_ready), .s(s64), .cout(co64),
    .ovf(of64), .zero(z64));

  typedef struct { logic [63:0] s; logic cout, ovf, zero; } res_t;
  typedef struct {
    logic [31:0] a, b; logic sub, cin;
    logic [31:0] s; logic cout, ovf, zero;
    logic [3:0] a4, b4; logic [63:0] a64, b64;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // plain arithmetic reference, independent of the lookahead structure
  function automatic res_t ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic sb, input logic ci);
    logic [64:0] mask, be, sum;
    res_t r;
    mask   = (65'd1 << w) - 65'd1;
    be     = {1'b0, sb ? ~b : b} & mask;
    sum    = ({1'b0, a} & mask) + be + {64'd0, sb ? ~ci : ci};
    r.s    = sum[63:0] & mask[63:0];
    r.cout = sum[w];
    r.ovf  = (a[w-1] == be[w-1]) && (sum[w-1] != a[w-1]);
    r.zero = (r.s == 64'd0);
    return r;
  endfunction

  task automatic chk_dut(input string tag, input logic v, input logic [63:0] sv,
                         input logic c, input logic o, input logic z, input res_t e);
    chk({tag, " valid"}, 64'(v), 64'd1);
    chk({tag, " s"}, sv, e.s);
    chk({tag, " cout/ovf/zero"}, {61'd0, c, o, z}, {61'd0, e.cout, e.ovf, e.zero});
  endtask

  task automatic chk_all(input string tag, input res_t e32, input res_t e4, input res_t e64);
    chk_dut({tag, "/w32"}, ov32, 64'(s32), co32, of32, z32, e32);
    chk_dut({tag, "/w4"},  ov4,  64'(s4),  co4,  of4,  z4,  e4);
    chk_dut({tag, "/w64"}, ov64, s64,      co64, of64, z64, e64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    res_t        e32, e4, e64;
    logic [31:0] ra[8], rb[8], ba[6], bb[6];
    logic [3:0]  r4a[8], r4b[8];
    logic [63:0] r64a[8], r64b[8];
    logic        rsub[8], rcin[8];
    int          acc, got;

    //          a             b             sub   cin   s             co    ovf   zero  a4    b4    a64                     b64
    tbl[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 4'h3, 4'h1, 64'h00000000FFFFFFFF, 64'h1};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 4'h7, 4'h1, 64'h7FFFFFFFFFFFFFFF, 64'h1};
    tbl[2] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 4'h8, 4'h1, 64'h8000000000000000, 64'h1};
    tbl[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 4'hF, 4'h1, 64'hFFFFFFFFFFFFFFFF, 64'h1};
    tbl[4] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4'h5, 4'h5, 64'h5, 64'h5};
    tbl[5] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 4'h5, 4'h5, 64'h5, 64'h5};
    tbl[6] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0, 4'h3, 4'h4, 64'h0123456789ABCDEF, 64'h1111111111111111};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 4'h8, 4'h8, 64'h8000000000000000, 64'h8000000000000000};
    tbl[8] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 64'h0, 64'h1};
    tbl[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset out_valid", {61'd0, ov32, ov4, ov64}, 64'd0);
    chk("reset s32", 64'(s32), 64'd0);
    chk("reset s64", s64, 64'd0);
    chk("reset flags32", {61'd0, co32, of32, z32}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", {61'd0, ir32, ir4, ir64}, 64'd7);

    // directed table: one op at a time, 2-cycle latency
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a32 = tbl[i].a;    b32 = tbl[i].b;
      a4  = tbl[i].a4;   b4  = tbl[i].b4;
      a64 = tbl[i].a64;  b64 = tbl[i].b64;
      sub = tbl[i].sub;  cin = tbl[i].cin;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d early valid", i), 64'(ov32), 64'd0);
      @(negedge clk);
      e32 = '{64'(tbl[i].s), tbl[i].cout, tbl[i].ovf, tbl[i].zero};
      e4  = ref_op(4,  64'(tbl[i].a4), 64'(tbl[i].b4), tbl[i].sub, tbl[i].cin);
      e64 = ref_op(64, tbl[i].a64, tbl[i].b64, tbl[i].sub, tbl[i].cin);
      chk_all($sformatf("vec%0d", i), e32, e4, e64);
    end

    // back-to-back stream of 8 ops
    for (int k = 0; k < 8; k++) begin
      ra[k] = $urandom; rb[k] = $urandom;
      r4a[k] = 4'($urandom); r4b[k] = 4'($urandom);
      r64a[k] = {$urandom, $urandom}; r64b[k] = {$urandom, $urandom};
      rsub[k] = 1'($urandom); rcin[k] = 1'($urandom);
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t < 8) begin
        a32 = ra[t]; b32 = rb[t]; a4 = r4a[t]; b4 = r4b[t];
        a64 = r64a[t]; b64 = r64b[t]; sub = rsub[t]; cin = rcin[t];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t < 8) chk("stream in_ready", {61'd0, ir32, ir4, ir64}, 64'd7);
      if (t < 2) chk("stream early valid", 64'(ov32), 64'd0);
      else begin
        e32 = ref_op(32, 64'(ra[t-2]), 64'(rb[t-2]), rsub[t-2], rcin[t-2]);
        e4  = ref_op(4, 64'(r4a[t-2]), 64'(r4b[t-2]), rsub[t-2], rcin[t-2]);
        e64 = ref_op(64, r64a[t-2], r64b[t-2], rsub[t-2], rcin[t-2]);
        chk_all($sformatf("stream%0d", t - 2), e32, e4, e64);
      end
    end
    @(negedge clk);
    chk("stream no extra", {61'd0, ov32, ov4, ov64}, 64'd0);

    // backpressure: out_ready low for 4 cycles while the source keeps offering
    for (int k = 0; k < 6; k++) begin ba[k] = $urandom; bb[k] = $urandom; end
    sub = 1'b0; cin = 1'b0; acc = 0; got = 0;
    for (int t = 0; t < 24 && got < 6; t++) begin
      @(negedge clk);
      out_ready = (t >= 4);
      in_valid  = (acc < 6);
      if (acc < 6) begin a32 = ba[acc]; b32 = bb[acc]; end
      #1;
      if (t == 2 || t == 3) begin
        chk("bp in_ready low", 64'(ir32), 64'd0);
        chk("bp valid held", 64'(ov32), 64'd1);
      end
      if (t == 4) chk("bp accepts before release", 64'(acc), 64'd2);
      if (ov32) begin
        chk($sformatf("bp data%0d", got), 64'(s32), 64'(32'(ba[got] + bb[got])));
        if (out_ready) got++;
      end
      if (in_valid && ir32) acc++;
    end
    chk("bp drained", 64'(got), 64'd6);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp no extra", 64'(ov32), 64'd0);

    // async reset with two ops in flight
    @(negedge clk);
    a32 = 32'h11111111; b32 = 32'h22222222; a4 = 4'h1; b4 = 4'h2;
    a64 = 64'h1; b64 = 64'h2; in_valid = 1'b1;
    @(negedge clk);
    a32 = 32'h0000FFFF; b32 = 32'h00000001;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst precondition valid", 64'(ov32), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async out_valid", {61'd0, ov32, ov4, ov64}, 64'd0);
    chk("rst async s32", 64'(s32), 64'd0);
    chk("rst async s64", s64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk($sformatf("rst no stale %0d", t), {61'd0, ov32, ov4, ov64}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with a second lookahead level over the groups.
- Uses a valid/ready handshake on both input and output, so it can sit in a datapath with backpressure at one result per cycle.
- Reports carry-out, signed overflow and zero flags. Its carry-in acts as borrow-in during subtraction, so instances can be chained for wider words.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4, legal range 4..64; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: A+B+cin; 1: A-B-cin (cin is borrow-in)
- cin  in  1  carry-in / borrow-in
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum / difference
- cout  out  1  carry-out (add) or NOT borrow-out (sub), i.e. raw adder carry
- ovf  out  1  signed two's-complement overflow
- zero  out  1  s == 0

Behaviour:
- Reset (async, rst_n=0): stage-1 valid=0, out_valid=0, s=0, cout=0, ovf=0, zero=0. Any in-flight operation is discarded and no output is produced for it. in_ready=1 once reset is released.
- Operand conditioning: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin.
- Per-bit signals: p = a ^ b_eff, g = a & b_eff. XOR propagate is mandatory.
- Stage 1 (registered on accept): per-bit p and g; per-group G/P for each 4-bit group; c0; MSB-carry inputs.
- Stage 2 (registered into the output):
  - Group carry-ins come from second-level lookahead over blocks of 4 groups. Carry passes combinationally from one block of 4 groups to the next.
  - In-group carries come from the lookahead.
  - s[i] = p[i] ^ c[i].
  - cout = carry out of bit WIDTH-1.
  - ovf = c[WIDTH-1] ^ cout.
  - zero = (s == 0).
- Latency: a result appears on out_valid exactly 2 cycles after the accepting edge, provided there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
  - s2_load = s1_valid & (~out_valid | out_ready).
  - in_ready = ~s1_valid | ~out_valid | out_ready. This is combinational and has no dependence on in_valid.
  - Pipeline stalls as a unit. While out_valid=1 and out_ready=0, s/cout/ovf/zero are held stable.
  - At most 2 results are in flight. Data is never dropped or duplicated.
- Simultaneous events:
  - Output transfer and new input accept in the same cycle: both occur; s1 advances to s2 and new data enters s1.
  - in_valid=0: s1_valid clears when its content moves to s2.
  - in_valid with in_ready=0: the block does not sample the operands. The source must hold them.
- Output data registers update only on s2_load. After reset they read 0 until the first load.
- Wrap-around: the sum is modulo 2^WIDTH. For example, all-ones + 1 with sub=0, cin=0 gives s=0, cout=1, zero=1.

Decomposition:
- Shared package cla_pkg:
  - localparam CLA_GROUP = 4.
  - A function giving the number of groups (WIDTH/4).
  - A function giving the number of second-level blocks (ceil(groups/4)).
- Natural sub-module: cla_lookahead4.
  - Inputs: p[3:0], g[3:0], ci.
  - Outputs: c[3:0] (c[0]=ci), group G, group P, co.
  - Instantiated once per group and once per block of 4 groups at the second level.
- Top level holds operand conditioning, the two pipeline registers, flag logic and handshake control.

Test Plan:
- WIDTH=32, a=0x0000FFFF, b=0x00000001, sub=0, cin=0, out_ready=1 -> 2 cycles later s=0x00010000, cout=0, ovf=0, zero=0.
- a=0x7FFFFFFF, b=0x00000001, add -> s=0x80000000, ovf=1, cout=0. Then a=0x80000000, b=0x00000001, sub=1, cin=0 -> s=0x7FFFFFFF, ovf=1, cout=1.
- a=0xFFFFFFFF, b=0x00000001, add -> s=0, cout=1, zero=1. Then a=5, b=5, sub=1, cin=1 (borrow) -> s=0xFFFFFFFF, cout=0.
- Back-to-back stream of 8 random operations with out_ready=1 -> 8 consecutive out_valid cycles, results in order and matching the reference model.
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready drops after 2 accepts, outputs are stable, nothing is lost. Release -> remaining results drain in order.
- Assert rst_n=0 mid-stream with 2 operations in flight -> out_valid=0 and s=0 immediately (async). After release, no stale result appears. Repeat the directed cases with WIDTH=4 and WIDTH=64.
